// File: rtl/cadr_shift_ctl_pkg.sv
// cadr_shift_pkg: shared types, defaults and rotate/mask helpers for cadr_shift_ctl.
// mask_build is compiled only with SHIFT_CTL_MASK_EN.
package cadr_shift_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int AMT_W_DEF = 5;
    // helpers work on a fixed container; callers pass the live width
    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [2:0] {S_IDLE, S_FINE, S_COARSE, S_MASK, S_DONE} state_t;

    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int amt, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) r[i] = x[IDX_W'((i + w - amt % w) % w)];
        return r;
    endfunction

`ifdef SHIFT_CTL_MASK_EN
    function automatic logic [MAX_W-1:0] mask_build(input int left, input int right, input int w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++)
            if (i < w) m[i] = (left >= right) ? (i >= right && i <= left) : (i >= right || i <= left);
        return m;
    endfunction
`endif
endpackage

// File: rtl/cadr_shift_ctl_if.sv
// cadr_shift_ctl_if: request/response channels and rotator rank controls.
interface cadr_shift_ctl_if
    import cadr_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [WIDTH-1:0]   req_data0, req_data1;
    logic [AMT_W-1:0]   req_amt0, req_amt1;
    logic [2*AMT_W-1:0] req_mask0, req_mask1;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [WIDTH-1:0]   resp_data;
    logic [1:0]         shf_sel;
    logic [AMT_W-3:0]   shf_csel;
    logic               shf_ce_n;

    modport master (
        output req_valid, req_data0, req_data1, req_amt0, req_amt1, req_mask0, req_mask1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, shf_sel, shf_csel, shf_ce_n
    );
    modport slave (
        input  req_valid, req_data0, req_data1, req_amt0, req_amt1, req_mask0, req_mask1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, shf_sel, shf_csel, shf_ce_n
    );
endinterface

// File: rtl/cadr_shift_ctl_arb.sv
// cadr_shift_rr_arb: two-way round-robin arbiter; on a tie the requester not granted last wins.
module cadr_shift_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_valid,
    input  logic       i_update,
    output logic [1:0] o_grant
);
    logic r_last;

    always_comb o_grant = (i_valid == 2'b11) ? (r_last ? 2'b01 : 2'b10) : i_valid;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_last <= 1'b1;
        else if (i_update) r_last <= o_grant[1];
endmodule

// File: rtl/cadr_shift_ctl.sv
// cadr_shift_ctl: arbitrates two rotate requesters and sequences the 25S10 fine/coarse ranks.
// SHIFT_CTL_MASK_EN adds a MASK pass that ANDs the result with a (possibly wrapping) bit range.
module cadr_shift_ctl
    import cadr_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input logic             clk,
    input logic             reset_n,
    cadr_shift_ctl_if.slave bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_data, r_resp_data, w_fine, w_coarse;
    logic [AMT_W-1:0] r_amt;
    logic [AMT_W-3:0] r_csel;
    logic [1:0]       r_sel, w_grant;
    logic             r_id, r_resp_valid, r_ce_n, w_hs;

    cadr_shift_rr_arb u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_valid  (bus.req_valid),
        .i_update (w_hs),
        .o_grant  (w_grant)
    );

    assign bus.req_ready  = (reset_n && r_state == S_IDLE) ? w_grant : 2'b00;
    assign w_hs           = |bus.req_ready;
    assign w_fine         = WIDTH'(rotl(MAX_W'(r_data), int'(r_amt[1:0]), WIDTH));
    assign w_coarse       = WIDTH'(rotl(MAX_W'(r_data), 4 * int'(r_amt[AMT_W-1:2]), WIDTH));
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.shf_sel    = r_sel;
    assign bus.shf_csel   = r_csel;
    assign bus.shf_ce_n   = r_ce_n;

`ifdef SHIFT_CTL_MASK_EN
    logic [2*AMT_W-1:0] r_mask;
    logic [WIDTH-1:0]   w_mask;
    assign w_mask = WIDTH'(mask_build(int'(r_mask[2*AMT_W-1:AMT_W]), int'(r_mask[AMT_W-1:0]), WIDTH));
`else
    logic w_unused_mask;
    assign w_unused_mask = ^{bus.req_mask0, bus.req_mask1};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_amt        <= '0;
            r_id         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_sel        <= '0;
            r_csel       <= '0;
            r_ce_n       <= 1'b1;
`ifdef SHIFT_CTL_MASK_EN
            r_mask       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_hs) begin
                    r_data  <= w_grant[1] ? bus.req_data1 : bus.req_data0;
                    r_amt   <= w_grant[1] ? bus.req_amt1 : bus.req_amt0;
                    r_sel   <= w_grant[1] ? bus.req_amt1[1:0] : bus.req_amt0[1:0];
                    r_id    <= w_grant[1];
                    r_ce_n  <= 1'b0;
                    r_state <= S_FINE;
`ifdef SHIFT_CTL_MASK_EN
                    r_mask  <= w_grant[1] ? bus.req_mask1 : bus.req_mask0;
`endif
                end
                S_FINE: begin
                    r_data  <= w_fine;
                    r_sel   <= '0;
                    r_csel  <= r_amt[AMT_W-1:2];
                    r_state <= S_COARSE;
                end
                S_COARSE: begin
                    r_csel <= '0;
                    r_ce_n <= 1'b1;
`ifdef SHIFT_CTL_MASK_EN
                    r_data  <= w_coarse;
                    r_state <= S_MASK;
`else
                    r_resp_data  <= w_coarse;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
`endif
                end
`ifdef SHIFT_CTL_MASK_EN
                S_MASK: begin
                    r_resp_data  <= r_data & w_mask;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
`endif
                S_DONE: if (bus.resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cadr_shift_ctl.sv
// tb_cadr_shift_ctl: directed and random requests checked against an arithmetic rotate/arbitration model.
module tb_cadr_shift_ctl;
    localparam int W = 32;
    localparam int A = 5;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   errors = 0;
    int   m_last = 1;

    cadr_shift_ctl_if #(.WIDTH(W), .AMT_W(A)) bus ();
    cadr_shift_ctl #(.WIDTH(W), .AMT_W(A)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_rot(input logic [31:0] d, input int a);
        logic [63:0] t;
        t = {d, d} << a;
        return t[63:32];
    endfunction

`ifdef SHIFT_CTL_MASK_EN
    function automatic logic [31:0] ref_mask(input int l, input int r);
        logic [63:0] m;
        m = (l >= r) ? (64'd1 << (l + 1)) - (64'd1 << r) : ~((64'd1 << r) - (64'd1 << (l + 1)));
        return m[31:0];
    endfunction
`endif

    // Starts in an IDLE cycle, ends in the first DONE cycle.
    task automatic run_txn(input logic [1:0] vld, output int w, output logic [31:0] want);
        int a;
        w = (vld == 2'b11) ? 1 - m_last : (vld[1] ? 1 : 0);
        a = w ? int'(bus.req_amt1) : int'(bus.req_amt0);
        want = ref_rot(w ? bus.req_data1 : bus.req_data0, a);
`ifdef SHIFT_CTL_MASK_EN
        want &= ref_mask(w ? int'(bus.req_mask1[9:5]) : int'(bus.req_mask0[9:5]),
                         w ? int'(bus.req_mask1[4:0]) : int'(bus.req_mask0[4:0]));
`endif
        bus.req_valid = vld;
        #1;
        chk("grant", 32'(bus.req_ready), 32'(2'b01 << w));
        tick();
        m_last = w;
        bus.req_valid = 2'($urandom);
        chk("fine_ce_n", 32'(bus.shf_ce_n), 0);
        chk("fine_sel", 32'(bus.shf_sel), a % 4);
        chk("fine_ready", 32'(bus.req_ready), 0);
        chk("fine_valid", 32'(bus.resp_valid), 0);
        tick();
        chk("coarse_ce_n", 32'(bus.shf_ce_n), 0);
        chk("coarse_csel", 32'(bus.shf_csel), a / 4);
        chk("coarse_sel", 32'(bus.shf_sel), 0);
`ifdef SHIFT_CTL_MASK_EN
        tick();
        chk("mask_valid", 32'(bus.resp_valid), 0);
`endif
        tick();
        chk("resp_valid", 32'(bus.resp_valid), 1);
        chk("resp_data", bus.resp_data, want);
        chk("resp_id", 32'(bus.resp_id), w);
        chk("done_ce_n", 32'(bus.shf_ce_n), 1);
        chk("done_ready", 32'(bus.req_ready), 0);
    endtask

    task automatic finish_txn();
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b1;
        tick();
        chk("idle_valid", 32'(bus.resp_valid), 0);
    endtask

    initial begin
        int w, stall;
        logic [31:0] want;
        reset_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        bus.req_amt0 = '0;
        bus.req_amt1 = '0;
        bus.req_mask0 = '0;
        bus.req_mask1 = '0;
        bus.resp_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.resp_valid), 0);
        chk("rst_ce_n", 32'(bus.shf_ce_n), 1);
        bus.req_valid = 2'b00;
        reset_n = 1'b1;
        tick();

        bus.req_data0 = 32'h0000_0001;
        bus.req_amt0 = 5'd5;
        run_txn(2'b01, w, want);
        chk("t1_data", bus.resp_data, 32'h0000_0020);
        finish_txn();
        bus.req_data1 = 32'h8000_0000;
        bus.req_amt1 = 5'd1;
        run_txn(2'b10, w, want);
        chk("t2_wrap", bus.resp_data, 32'h0000_0001);
        finish_txn();
        bus.req_data0 = 32'h1234_5678;
        bus.req_amt0 = 5'd0;
        run_txn(2'b01, w, want);
        chk("t3_amt0", bus.resp_data, 32'h1234_5678);
        finish_txn();

`ifdef SHIFT_CTL_MASK_EN
        bus.req_data0 = 32'hFFFF_FFFF;
        bus.req_mask0 = {5'd7, 5'd4};
        run_txn(2'b01, w, want);
        chk("m1_data", bus.resp_data, 32'h0000_00F0);
        finish_txn();
        bus.req_mask0 = {5'd1, 5'd30};
        run_txn(2'b01, w, want);
        chk("m2_wrap", bus.resp_data, 32'hC000_0003);
        finish_txn();
`endif

        // backpressure with the other requester waiting
        bus.resp_ready = 1'b0;
        bus.req_data1 = 32'hA5C3_0F96;
        bus.req_amt1 = 5'd13;
        run_txn(2'b10, w, want);
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = 2'b01;
            tick();
            chk("bp_valid", 32'(bus.resp_valid), 1);
            chk("bp_data", bus.resp_data, want);
            chk("bp_id", 32'(bus.resp_id), w);
            chk("bp_ready", 32'(bus.req_ready), 0);
        end
        finish_txn();

        // reset during COARSE drops the operation
        bus.req_data0 = 32'hDEAD_BEEF;
        bus.req_amt0 = 5'd22;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk("pre_rst_ce_n", 32'(bus.shf_ce_n), 0);
        reset_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("ar_ready", 32'(bus.req_ready), 0);
        chk("ar_valid", 32'(bus.resp_valid), 0);
        chk("ar_id", 32'(bus.resp_id), 0);
        chk("ar_data", bus.resp_data, 0);
        chk("ar_sel", 32'(bus.shf_sel), 0);
        chk("ar_csel", 32'(bus.shf_csel), 0);
        chk("ar_ce_n", 32'(bus.shf_ce_n), 1);
        tick();
        bus.req_valid = 2'b00;
        reset_n = 1'b1;
        m_last = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_valid", 32'(bus.resp_valid), 0);
        end

        // ties alternate starting with requester 0
        for (int k = 0; k < 4; k++) begin
            bus.req_data0 = $urandom;
            bus.req_data1 = $urandom;
            bus.req_amt0 = 5'($urandom);
            bus.req_amt1 = 5'($urandom);
            run_txn(2'b11, w, want);
            chk("rr_id", 32'(bus.resp_id), k % 2);
            finish_txn();
        end

        for (int k = 0; k < 30; k++) begin
            bus.req_data0 = $urandom;
            bus.req_data1 = $urandom;
            bus.req_amt0 = 5'($urandom);
            bus.req_amt1 = 5'($urandom);
            bus.req_mask0 = 10'($urandom);
            bus.req_mask1 = 10'($urandom);
            stall = $urandom_range(0, 3);
            bus.resp_ready = (stall == 0);
            run_txn(2'($urandom_range(1, 3)), w, want);
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("rnd_hold", bus.resp_data, want);
            end
            finish_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cadr_shift_ctl.md
# cadr_shift_ctl

Sequencer and arbiter for the shared 32-bit rotator built from 25S10 shifter slices. It accepts rotate requests from two requesters (0 = microcode datapath, 1 = spy/debug port) and grants them round-robin. For each request it runs a fixed pass sequence through the rotator ranks: fine rank (0–3 bits), then coarse rank (multiples of 4). It drives the rank select and enable lines and returns the rotated word over a valid/ready response channel.

## Interface
Parameters:
- WIDTH, 32, data word width; must be a multiple of 4 (25S10 slice width).
- AMT_W, 5, rotate-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request accepted; at most one bit set.
- req_data0, req_data1  in  WIDTH  word to rotate.
- req_amt0, req_amt1  in  AMT_W  left-rotate amount.
- req_mask0, req_mask1  in  2*AMT_W  {left bound, right bound} mask field; used only with SHIFT_CTL_MASK_EN.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that owns the result.
- resp_data  out  WIDTH  rotated (optionally masked) word.
- shf_sel  out  2  fine-rank select; equals SEL1/SEL0 on every 25S10 in the rank.
- shf_csel  out  AMT_W-2  coarse-rank nibble select.
- shf_ce_n  out  1  rank output enable, active low.

## Operation
- FSM states: IDLE, FINE, COARSE, MASK (only when compiled in), DONE.
- IDLE:
  - Arbitrate among requesters with req_valid set. Round-robin favours the requester not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - req_ready is asserted for the winner only, combinationally.
  - On handshake, latch data, amount, mask and id, update last_grant, and go to FINE.
- FINE:
  - shf_ce_n=0, shf_sel=amt[1:0].
  - Working word rotates left by amt[1:0].
  - Go to COARSE.
- COARSE:
  - shf_ce_n=0, shf_csel=amt[AMT_W-1:2].
  - Working word rotates left by 4*amt[AMT_W-1:2].
  - Go to MASK if compiled in, else DONE.
- DONE:
  - resp_valid=1; resp_data and resp_id are held stable.
  - On resp_ready, return to IDLE. Arbitration for the next request happens in that IDLE cycle, not in DONE.
- Rotation is modulo WIDTH: bits shifted out of the MSB wrap to the LSB. Amount 0 passes the data unchanged through both passes.
- Outside FINE/COARSE: shf_ce_n=1, shf_sel=0, shf_csel=0.
- A requester may drop req_valid before it is granted, with no side effects.

## Timing
- Reset values: req_ready=0 while reset_n is low, resp_valid=0, resp_id=0, resp_data=0, shf_sel=0, shf_csel=0, shf_ce_n=1, state=IDLE, last_grant=1.
- Latency: handshake in cycle 0, FINE in cycle 1, COARSE in cycle 2, resp_valid high from cycle 3. With the mask stage, resp_valid is high from cycle 4.
- Throughput: one request per 4 cycles (5 with mask) when resp_ready is tied high.
- Backpressure: DONE holds indefinitely with outputs stable. req_ready stays 0 while busy.
- Reset asserted mid-operation aborts the operation immediately and drops the result. No response is issued for it.
- Simultaneous valid on both requesters: exactly one grant per IDLE cycle.

## Configuration
- SHIFT_CTL_MASK_EN:
  - Defined: add the MASK state after COARSE. The working word is ANDed with a contiguous mask covering bits right..left inclusive.
  - If left<right, the mask wraps: bits right..WIDTH-1 and 0..left are set.
  - Undefined: no MASK state, mask inputs are ignored, latency is 3.

## Structure
- Package cadr_shift_pkg:
  - state enum;
  - WIDTH/AMT_W defaults;
  - rotl() function;
  - mask-build function (under the macro).
- One sub-module, cadr_shift_rr_arb: the 2-way round-robin arbiter (valid in, one-hot grant out, last_grant register with update enable).

## Test plan
- Req0 data=0x00000001, amt=5, resp_ready=1 → cycle 1 shf_sel=1; cycle 2 shf_csel=1; cycle 3 resp_valid=1, resp_data=0x00000020, resp_id=0.
- Req1 data=0x80000000, amt=1 → resp_data=0x00000001 (wrap-around). Also amt=0, data=0x12345678 → resp_data=0x12345678.
- Both req_valid held high for 4 requests → grants in order 0,1,0,1, and req_ready is never set for both at once.
- resp_ready low for 10 cycles in DONE → resp_valid, resp_data and resp_id stable, req_ready=0; release returns the FSM to IDLE.
- reset_n pulsed low during COARSE → all outputs return to reset values and no response is issued; the next request completes normally.
- With SHIFT_CTL_MASK_EN: data=0xFFFFFFFF, amt=0, mask {left=7, right=4} → resp_data=0x000000F0 at cycle 4. With left=1, right=30 → resp_data=0xC0000003.
